// File: rtl/ux607_sram_icb_fillchk.sv
// SRAM fill/check engine over an ICB initiator port: writes word_cnt words of a
// constant or incrementing pattern, then optionally reads them back and compares.
module ux607_sram_icb_fillchk #(
  parameter int DW     = 32,
  parameter int MW     = 4,
  parameter int AW     = 32,
  parameter int USR_W  = 3,
  parameter int CNT_W  = 16,
  parameter int OUTS_N = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              chk_en,
  input  logic              inc_en,
  input  logic [AW-1:0]     base_addr,
  input  logic [CNT_W-1:0]  word_cnt,
  input  logic [DW-1:0]     pattern,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [AW-1:0]     err_addr,
  output logic [2:0]        state_dbg,
  output logic              o_icb_cmd_valid,
  input  logic              o_icb_cmd_ready,
  output logic              o_icb_cmd_read,
  output logic [AW-1:0]     o_icb_cmd_addr,
  output logic [DW-1:0]     o_icb_cmd_wdata,
  output logic [MW-1:0]     o_icb_cmd_wmask,
  output logic [USR_W-1:0]  o_icb_cmd_usr,
  input  logic              o_icb_rsp_valid,
  output logic              o_icb_rsp_ready,
  input  logic [DW-1:0]     o_icb_rsp_rdata,
  input  logic [USR_W-1:0]  o_icb_rsp_usr
);

  localparam int OW = $clog2(OUTS_N + 1);
  localparam logic [AW-1:0] STRIDE = AW'(MW);

  typedef enum logic [2:0] {IDLE, WR, WDRAIN, RD, RDRAIN, DONE} state_t;

  // Handshakes: a command transfers on a clock edge where o_icb_cmd_valid and
  // o_icb_cmd_ready are both 1; a response transfers where o_icb_rsp_valid and
  // o_icb_rsp_ready are both 1. Once valid rises, the command fields stay put
  // until the transfer happens.

  state_t            state, state_nxt;
  logic              chk_q, inc_q;
  logic [AW-1:0]     base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DW-1:0]     pat_q;
  logic [CNT_W-1:0]  idx;
  logic [CNT_W-1:0]  ridx;
  logic [OW-1:0]     outs;

  logic              cmd_hs, rsp_hs, last_cmd, enter_rd, accept;
  logic [DW-1:0]     cmd_data, exp_data;
  logic [AW-1:0]     rsp_addr;
  logic              unused_rsp_usr;

  assign unused_rsp_usr = ^o_icb_rsp_usr;

  assign o_icb_cmd_valid = (state == WR || state == RD) && (idx < cnt_q) && (outs < OW'(OUTS_N));
  assign o_icb_rsp_ready = (state != IDLE);
  assign cmd_hs   = o_icb_cmd_valid && o_icb_cmd_ready;
  assign rsp_hs   = o_icb_rsp_valid && o_icb_rsp_ready;
  assign last_cmd = cmd_hs && ((idx + CNT_W'(1)) == cnt_q);
  assign enter_rd = (state == WDRAIN) && (outs == '0) && chk_q;
  assign accept   = (state == IDLE) && start;

  assign cmd_data = inc_q ? (pat_q + DW'(idx)) : pat_q;
  assign exp_data = inc_q ? (pat_q + DW'(ridx)) : pat_q;
  assign rsp_addr = base_q + AW'(ridx) * STRIDE;

  // Fields are forced to zero whenever no command is offered so idle/reset look clean.
  assign o_icb_cmd_read  = o_icb_cmd_valid && (state == RD);
  assign o_icb_cmd_addr  = o_icb_cmd_valid ? (base_q + AW'(idx) * STRIDE) : '0;
  assign o_icb_cmd_wdata = (o_icb_cmd_valid && state == WR) ? cmd_data : '0;
  assign o_icb_cmd_wmask = o_icb_cmd_valid ? '1 : '0;
  assign o_icb_cmd_usr   = '0;

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (word_cnt != '0) ? WR : DONE;
      WR:      if (last_cmd) state_nxt = WDRAIN;
      WDRAIN:  if (outs == '0) state_nxt = chk_q ? RD : DONE;
      RD:      if (last_cmd) state_nxt = RDRAIN;
      RDRAIN:  if (outs == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      chk_q    <= 1'b0;
      inc_q    <= 1'b0;
      base_q   <= '0;
      cnt_q    <= '0;
      pat_q    <= '0;
      idx      <= '0;
      ridx     <= '0;
      outs     <= '0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        chk_q    <= chk_en;
        inc_q    <= inc_en;
        base_q   <= base_addr;
        cnt_q    <= word_cnt;
        pat_q    <= pattern;
        idx      <= '0;
        ridx     <= '0;
        err      <= 1'b0;
        err_addr <= '0;
      end else begin
        if (enter_rd) idx <= '0;
        else if (cmd_hs) idx <= idx + CNT_W'(1);
        // Responses return in issue order, so the response counter names the word.
        if (enter_rd) begin
          ridx <= '0;
        end else if (rsp_hs && (state == RD || state == RDRAIN)) begin
          ridx <= ridx + CNT_W'(1);
          if (o_icb_rsp_rdata != exp_data) begin
            err <= 1'b1;
            if (!err) err_addr <= rsp_addr;
          end
        end
      end
      if (cmd_hs && !rsp_hs) outs <= outs + OW'(1);
      else if (!cmd_hs && rsp_hs && outs != '0) outs <= outs - OW'(1);
    end
  end

endmodule
